// File: rtl/rs232_rx_pkg.sv
//============================================================================
// Module   : rs232_rx_pkg
// Purpose  : Shared definitions for the RS-232 receiver (and usable by the
//            matching transmitter): default line/clock rates, receiver
//            state encoding and the odd-parity helper.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

package rs232_rx_pkg;

    // Default operating point: 9600 baud from a 50 MHz system clock.
    localparam int c_default_baud  = 9600;
    localparam int c_default_reloj = 50_000_000;

    // Minimum width of the bit-cell counter (5208 cycles needs 13 bits).
    localparam int c_min_cnt_w = 13;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } rx_state_t;

    // Parity bit value that makes (data ones + parity bit) odd.
    function automatic logic odd_parity(input logic [7:0] data);
        return ~^data;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rs232_rx_if.sv
//============================================================================
// Module   : rs232_rx_if
// Purpose  : Serial line and received-byte bundle of the RS-232 receiver.
//   RX   : serial line, idle high (driven by the line side)
//   D    : last received byte
//   RDY  : one-cycle pulse, D/PERR/FERR updated
//   PERR : parity error of last frame
//   FERR : framing error of last frame
//   BUSY : frame reception in progress
//   master = receiver, slave = line driver / byte consumer
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

interface rs232_rx_if;
    logic       RX;
    logic [7:0] D;
    logic       RDY;
    logic       PERR;
    logic       FERR;
    logic       BUSY;

    modport master (
        input  RX,
        output D, RDY, PERR, FERR, BUSY
    );

    modport slave (
        output RX,
        input  D, RDY, PERR, FERR, BUSY
    );
endinterface

`default_nettype wire

// File: rtl/rs232_rx_baud_tick.sv
//============================================================================
// Module   : rs232_rx_baud_tick
// Purpose  : Bit-cell timer. Counts 0..CONTA-1 while enabled and flags the
//            half-cell and full-cell points.
//   clk, reset : system clock, asynchronous active-high reset
//   i_clr      : synchronous clear of the counter (wins over i_en)
//   i_en       : count enable
//   o_half     : counter at CONTA/2-1
//   o_full     : counter at CONTA-1 (counter wraps to 0 next cycle)
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rs232_rx_baud_tick
    import rs232_rx_pkg::*;
#(
    parameter int CONTA = 5208
) (
    input  wire logic clk,
    input  wire logic reset,
    input  wire logic i_clr,
    input  wire logic i_en,
    output logic      o_half,
    output logic      o_full
);

    localparam int c_w = ($clog2(CONTA) > c_min_cnt_w) ? $clog2(CONTA) : c_min_cnt_w;

    localparam logic [c_w-1:0] c_half_last = c_w'(CONTA / 2 - 1);
    localparam logic [c_w-1:0] c_full_last = c_w'(CONTA - 1);
    localparam logic [c_w-1:0] c_one       = c_w'(1);

    logic [c_w-1:0] r_k;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_k <= '0;
        end else if (i_clr) begin
            r_k <= '0;
        end else if (i_en) begin
            r_k <= (r_k == c_full_last) ? '0 : r_k + c_one;
        end
    end

    assign o_half = i_en && (r_k == c_half_last);
    assign o_full = i_en && (r_k == c_full_last);

endmodule

`default_nettype wire

// File: rtl/rs232_rx.sv
//============================================================================
// Module   : rs232_rx
// Purpose  : RS-232 UART receiver, 8 data bits LSB first, odd parity, one
//            stop bit. RX is synchronised, a start edge is validated at
//            mid-cell and every following bit is sampled mid-cell.
//   clk    : system clock
//   reset  : asynchronous, active-high reset
//   rx_bus : rs232_rx_if.master (RX in; D, RDY, PERR, FERR, BUSY out)
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none

module rs232_rx
    import rs232_rx_pkg::*;
#(
    parameter int BAUD_RATE = c_default_baud,
    parameter int RELOJ     = c_default_reloj
) (
    input  wire logic   clk,
    input  wire logic   reset,
    rs232_rx_if.master  rx_bus
);

    localparam int CONTA = RELOJ / BAUD_RATE;

    logic       r_rx_meta;
    logic       r_rx_s;
    logic       r_rx_p;

    rx_state_t  r_state;
    logic [7:0] r_shift;
    logic [2:0] r_bitcnt;
    logic       r_perr_n;

    logic [7:0] r_d;
    logic       r_rdy;
    logic       r_perr;
    logic       r_ferr;
    logic       r_busy;

    logic       w_half;
    logic       w_full;
    logic       w_clr;
    logic       w_en;

    // Two-stage synchroniser plus one history stage for edge detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_p    <= 1'b1;
        end else begin
            r_rx_meta <= rx_bus.RX;
            r_rx_s    <= r_rx_meta;
            r_rx_p    <= r_rx_s;
        end
    end

    // The counter is held at zero in IDLE and re-zeroed at the start-bit
    // mid-point so that every later full tick lands mid-cell. The other
    // state changes happen on a full tick, where the counter wraps anyway.
    assign w_clr = (r_state == IDLE) || ((r_state == START) && w_half);
    assign w_en  = (r_state != IDLE);

    rs232_rx_baud_tick #(
        .CONTA (CONTA)
    ) u_baud_tick (
        .clk    (clk),
        .reset  (reset),
        .i_clr  (w_clr),
        .i_en   (w_en),
        .o_half (w_half),
        .o_full (w_full)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state  <= IDLE;
            r_shift  <= 8'h00;
            r_bitcnt <= 3'd0;
            r_perr_n <= 1'b0;
            r_d      <= 8'h00;
            r_rdy    <= 1'b0;
            r_perr   <= 1'b0;
            r_ferr   <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_rdy <= 1'b0;
            case (r_state)
                IDLE: begin
                    // Only a high-to-low transition starts a frame, so a
                    // line held low never retriggers.
                    if (r_rx_p && !r_rx_s) begin
                        r_state <= START;
                        r_busy  <= 1'b1;
                    end
                end
                START: begin
                    if (w_half) begin
                        if (!r_rx_s) begin
                            r_state  <= DATA;
                            r_bitcnt <= 3'd0;
                        end else begin
                            r_state <= IDLE;
                            r_busy  <= 1'b0;
                        end
                    end
                end
                DATA: begin
                    if (w_full) begin
                        r_shift  <= {r_rx_s, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 3'd1;
                        if (r_bitcnt == 3'd7) begin
                            r_state <= PARITY;
                        end
                    end
                end
                PARITY: begin
                    if (w_full) begin
                        r_perr_n <= (r_rx_s != odd_parity(r_shift));
                        r_state  <= STOP;
                    end
                end
                STOP: begin
                    // Returning to IDLE at mid-stop-bit leaves half a cell
                    // to catch a back-to-back start edge.
                    if (w_full) begin
                        r_d     <= r_shift;
                        r_perr  <= r_perr_n;
                        r_ferr  <= ~r_rx_s;
                        r_rdy   <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.D    = r_d;
    assign rx_bus.RDY  = r_rdy;
    assign rx_bus.PERR = r_perr;
    assign rx_bus.FERR = r_ferr;
    assign rx_bus.BUSY = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_rs232_rx.sv
//============================================================================
// Module   : tb_rs232_rx
// Purpose  : Self-checking bench for rs232_rx. Frames are driven on RX in
//            real time (bit cell = CONTA clocks, optionally skewed); the
//            expected byte/flags are queued when a frame is launched and a
//            monitor pops and compares on every RDY pulse.
// Revision : 1.0 - initial release
//============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_rs232_rx;

    localparam int  BAUD   = 10;
    localparam int  RELOJ  = 500;
    localparam int  CONTA  = RELOJ / BAUD;
    localparam real CLK_NS = 10.0;
    localparam real BIT_NS = CONTA * CLK_NS;

    typedef struct {
        logic [7:0] d;
        logic       perr;
        logic       ferr;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb[$];
    logic [7:0] last_d = 8'h00;
    logic prev_rdy = 1'b0;

    always #5 clk = ~clk;

    rs232_rx_if rif ();

    rs232_rx #(
        .BAUD_RATE (BAUD),
        .RELOJ     (RELOJ)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .rx_bus (rif)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // Reference rules: the frame is good when data ones plus parity bit
    // are odd; framing is good when the stop bit is 1.
    function automatic logic model_perr(input logic [7:0] d, input logic p);
        return (($countones(d) + int'(p)) % 2) == 0;
    endfunction

    function automatic logic good_parity(input logic [7:0] d);
        return ($countones(d) % 2) == 0;
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input real bn);
        exp_t e;
        e.d    = d;
        e.perr = model_perr(d, p);
        e.ferr = !s;
        sb.push_back(e);
        rif.RX = 1'b0;
        #(bn);
        for (int i = 0; i < 8; i++) begin
            rif.RX = d[i];
            #(bn);
        end
        rif.RX = p;
        #(bn);
        rif.RX = s;
        #(bn);
    endtask

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (reset) begin
            prev_rdy = 1'b0;
        end else begin
            if (rif.RDY) begin
                exp_t e;
                chk("rdy_one_cycle", 32'(prev_rdy), 32'd0);
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_rdy: actual RDY=1 D=%0h required no RDY at %0t", rif.D, $time);
                end else begin
                    e = sb.pop_front();
                    chk("D", 32'(rif.D), 32'(e.d));
                    chk("PERR", 32'(rif.PERR), 32'(e.perr));
                    chk("FERR", 32'(rif.FERR), 32'(e.ferr));
                    chk("busy_at_rdy", 32'(rif.BUSY), 32'd0);
                    last_d = e.d;
                end
            end
            prev_rdy = rif.RDY;
        end
    end

    initial begin
        #(800_000);
        $display("FAIL watchdog: actual=timeout required=finish checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] d;
        logic       p;
        logic       s;
        logic [7:0] abort_byte;
        real        bn;

        rif.RX = 1'b1;
        reset  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_D", 32'(rif.D), 32'd0);
        chk("reset_RDY", 32'(rif.RDY), 32'd0);
        chk("reset_PERR", 32'(rif.PERR), 32'd0);
        chk("reset_FERR", 32'(rif.FERR), 32'd0);
        chk("reset_BUSY", 32'(rif.BUSY), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #(2 * BIT_NS);

        // Clean frame.
        send_frame(8'h55, 1'b1, 1'b1, BIT_NS);
        rif.RX = 1'b1;
        #(BIT_NS);
        chk("t1_busy_after", 32'(rif.BUSY), 32'd0);

        // Wrong parity.
        send_frame(8'hA7, 1'b1, 1'b1, BIT_NS);
        rif.RX = 1'b1;
        #(BIT_NS);

        // Stop bit low, then line held low: no retrigger.
        send_frame(8'h3C, 1'b1, 1'b0, BIT_NS);
        #(2 * BIT_NS);
        chk("t3_break_busy", 32'(rif.BUSY), 32'd0);
        rif.RX = 1'b1;
        #(BIT_NS);

        // Short low glitch on an idle line.
        #(3.3);
        rif.RX = 1'b0;
        #60;
        chk("t4_glitch_busy_high", 32'(rif.BUSY), 32'd1);
        #40;
        rif.RX = 1'b1;
        #300;
        chk("t4_glitch_busy_low", 32'(rif.BUSY), 32'd0);
        chk("t4_glitch_D_kept", 32'(rif.D), 32'(last_d));
        #(BIT_NS);

        // Reset during bit 4 of 0x81: partial frame discarded.
        abort_byte = 8'h81;
        rif.RX = 1'b0;
        #(BIT_NS);
        for (int i = 0; i < 4; i++) begin
            rif.RX = abort_byte[i];
            #(BIT_NS);
        end
        rif.RX = abort_byte[4];
        #(BIT_NS / 2.0);
        reset = 1'b1;
        #1;
        chk("t5_reset_D", 32'(rif.D), 32'd0);
        chk("t5_reset_PERR", 32'(rif.PERR), 32'd0);
        chk("t5_reset_FERR", 32'(rif.FERR), 32'd0);
        chk("t5_reset_BUSY", 32'(rif.BUSY), 32'd0);
        chk("t5_reset_RDY", 32'(rif.RDY), 32'd0);
        rif.RX = 1'b1;
        #(BIT_NS);
        @(negedge clk);
        reset = 1'b0;
        #(BIT_NS);
        send_frame(8'h3C, 1'b1, 1'b1, BIT_NS);
        rif.RX = 1'b1;
        #(BIT_NS);

        // Back-to-back frames with +/-2% baud skew.
        send_frame(8'h00, 1'b1, 1'b1, BIT_NS * 1.02);
        send_frame(8'hFF, 1'b1, 1'b1, BIT_NS * 0.98);
        send_frame(8'hFF, 1'b1, 1'b1, BIT_NS * 0.98);
        send_frame(8'h00, 1'b1, 1'b1, BIT_NS * 1.02);
        rif.RX = 1'b1;
        #(BIT_NS);

        // Randomised frames: random data, occasional bad parity/stop,
        // skew within +/-2%, random idle gaps down to zero.
        for (int n = 0; n < 24; n++) begin
            d  = 8'($urandom_range(0, 255));
            p  = good_parity(d) ^ ($urandom_range(0, 3) == 0);
            s  = ($urandom_range(0, 7) != 0);
            bn = BIT_NS * (1.0 + (real'($urandom_range(0, 40)) - 20.0) / 1000.0);
            send_frame(d, p, s, bn);
            rif.RX = 1'b1;
            if (!s) begin
                #(BIT_NS);
            end
            #($urandom_range(0, 500));
        end

        rif.RX = 1'b1;
        #(2 * BIT_NS);
        chk("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
